// File: rtl/fft64_input_stager_if.sv
// Sample-in / row-out bundle for the 64-point FFT input stager.
// Framing-check signals exist only with FFT64_STAGER_FRAME_CHK_EN.
interface fft64_input_stager_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] SET_0_OUT;
    logic [DATA_W-1:0] SET_1_OUT;
    logic [DATA_W-1:0] SET_2_OUT;
    logic [DATA_W-1:0] SET_3_OUT;
    logic [DATA_W-1:0] SET_4_OUT;
    logic [DATA_W-1:0] SET_5_OUT;
    logic [DATA_W-1:0] SET_6_OUT;
    logic [DATA_W-1:0] SET_7_OUT;
    logic              m_valid;
    logic              m_ready;
    logic [2:0]        m_row;
    logic              m_last;
`ifdef FFT64_STAGER_FRAME_CHK_EN
    logic              s_last;
    logic              frame_err;
`endif

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_valid, m_row, m_last,
        output SET_0_OUT, SET_1_OUT, SET_2_OUT, SET_3_OUT,
        output SET_4_OUT, SET_5_OUT, SET_6_OUT, SET_7_OUT
`ifdef FFT64_STAGER_FRAME_CHK_EN
        , input s_last
        , output frame_err
`endif
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_valid, m_row, m_last,
        input  SET_0_OUT, SET_1_OUT, SET_2_OUT, SET_3_OUT,
        input  SET_4_OUT, SET_5_OUT, SET_6_OUT, SET_7_OUT
`ifdef FFT64_STAGER_FRAME_CHK_EN
        , output s_last
        , input frame_err
`endif
    );
endinterface

// File: rtl/fft64_input_stager.sv
// Ping-pong serial-to-parallel stager: 64 samples in, 8 rows of 8 lanes out.
// Optional framing check enabled by FFT64_STAGER_FRAME_CHK_EN.
module fft64_input_stager #(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fft64_input_stager_if.slave  bus
);
    logic [DATA_W-1:0] mem [128];
    logic              wr_bank;
    logic              rd_bank;
    logic [5:0]        wr_cnt;
    logic [2:0]        rd_row;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              s_ready;
    logic              m_valid;
    logic              accept;
    logic              take;
    logic              fill_done;
    logic              drain_done;
    logic [DATA_W-1:0] lane [8];

    assign s_ready    = !full[wr_bank];
    assign m_valid    = full[rd_bank];
    assign accept     = bus.s_valid && s_ready;
    assign take       = m_valid && bus.m_ready;
    assign fill_done  = accept && (wr_cnt == 6'd63);
    assign drain_done = take && (rd_row == 3'd7);

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_row   = rd_row;
    assign bus.m_last  = m_valid && (rd_row == 3'd7);

    // Sample storage, addressed {bank, index}; deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept)
            mem[{wr_bank, wr_cnt}] <= bus.s_data;
    end

    // Fill sets its bank's flag, drain clears its own; they never collide.
    always_comb begin
        full_nxt = full;
        if (fill_done)
            full_nxt[wr_bank] = 1'b1;
        if (drain_done)
            full_nxt[rd_bank] = 1'b0;
    end

    // Write/read pointers and bank-full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= 6'd0;
            rd_bank <= 1'b0;
            rd_row  <= 3'd0;
            full    <= 2'b00;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (fill_done)
                    wr_bank <= ~wr_bank;
            end
            if (take) begin
                rd_row <= rd_row + 3'd1;
                if (drain_done)
                    rd_bank <= ~rd_bank;
            end
        end
    end

    // Lane k of row r is sample 8*k + r, i.e. index {k, r} within the bank.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane[k] = '0;
            if (m_valid)
                lane[k] = mem[{rd_bank, 3'(k), rd_row}];
        end
    end

    assign bus.SET_0_OUT = lane[0];
    assign bus.SET_1_OUT = lane[1];
    assign bus.SET_2_OUT = lane[2];
    assign bus.SET_3_OUT = lane[3];
    assign bus.SET_4_OUT = lane[4];
    assign bus.SET_5_OUT = lane[5];
    assign bus.SET_6_OUT = lane[6];
    assign bus.SET_7_OUT = lane[7];

`ifdef FFT64_STAGER_FRAME_CHK_EN
    logic frame_err;

    assign bus.frame_err = frame_err;

    // Sticky flag: s_last must coincide exactly with the 64th sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_err <= 1'b0;
        else if (accept && (bus.s_last != (wr_cnt == 6'd63)))
            frame_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft64_input_stager.sv
// Directed bench for fft64_input_stager.
// Samples carry {frame tag, index n} so every lane is self-identifying.
module tb_fft64_input_stager;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fft64_input_stager_if #(.DATA_W(W)) bus ();

    fft64_input_stager #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] lane [8];

    assign lane[0] = bus.SET_0_OUT;
    assign lane[1] = bus.SET_1_OUT;
    assign lane[2] = bus.SET_2_OUT;
    assign lane[3] = bus.SET_3_OUT;
    assign lane[4] = bus.SET_4_OUT;
    assign lane[5] = bus.SET_5_OUT;
    assign lane[6] = bus.SET_6_OUT;
    assign lane[7] = bus.SET_7_OUT;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] smp(input int tag, input int n);
        return {tag[15:0], n[15:0]};
    endfunction

    task automatic check_row(input int tag, input int r);
        check($sformatf("m_row_f%0d_r%0d", tag, r), 32'(bus.m_row), r);
        check($sformatf("m_last_f%0d_r%0d", tag, r),
              32'(bus.m_last), 32'(r == 7));
        for (int k = 0; k < 8; k++)
            check($sformatf("lane%0d_f%0d_r%0d", k, tag, r),
                  lane[k], smp(tag, 8 * k + r));
    endtask

    // One sample, accepted at the next posedge when s_ready is high.
    task automatic push1(input int tag, input int n, input bit last);
        check($sformatf("push_ready_f%0d_n%0d", tag, n),
              32'(bus.s_ready), 1);
        bus.s_valid = 1'b1;
        bus.s_data  = smp(tag, n);
`ifdef FFT64_STAGER_FRAME_CHK_EN
        bus.s_last  = last;
`else
        if (last) bus.s_data = smp(tag, n);
`endif
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic produce(input int tag0, input int nfr,
                           input bit chk_rdy, input int budget);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < nfr * 64 && cyc < budget) begin
            bus.s_valid = 1'b1;
            bus.s_data  = smp(tag0 + idx / 64, idx % 64);
`ifdef FFT64_STAGER_FRAME_CHK_EN
            bus.s_last  = (idx % 64 == 63);
`endif
            if (chk_rdy)
                check("s_ready_stream", 32'(bus.s_ready), 1);
            if (bus.s_ready)
                idx++;
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        check("produce_count", idx, nfr * 64);
    endtask

    task automatic drain(input int tag0, input int nfr, input bit toggle,
                         input int budget, input bit idle_chk);
        int rows;
        int cyc;
        bit rdy;
        rows = 0;
        cyc = 0;
        while (rows < nfr * 8 && cyc < budget) begin
            rdy = toggle ? cyc[0] : 1'b1;
            bus.m_ready = rdy;
            if (bus.m_valid) begin
                check_row(tag0 + rows / 8, rows % 8);
                if (rdy)
                    rows++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.m_ready = 1'b0;
        check("drain_rows", rows, nfr * 8);
        if (idle_chk)
            check("drain_idle_m_valid", 32'(bus.m_valid), 0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
`ifdef FFT64_STAGER_FRAME_CHK_EN
        bus.s_last  = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready), 1);
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_m_row", 32'(bus.m_row), 0);
        check("rst_m_last", 32'(bus.m_last), 0);
        check("rst_set0", lane[0], 0);
        rst = 1'b0;
        @(negedge clk);

        // Full frame held plus a partial fill, then async reset.
        produce(16'h50, 1, 1'b0, 200);
        check("pre_rst_m_valid", 32'(bus.m_valid), 1);
        for (int i = 0; i < 20; i++)
            push1(16'h51, i, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_s_ready", 32'(bus.s_ready), 1);
        check("arst_m_valid", 32'(bus.m_valid), 0);
        check("arst_m_row", 32'(bus.m_row), 0);
        check("arst_set0", lane[0], 0);
        check("arst_set7", lane[7], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frame, n = 0..63, ready held high.
        bus.m_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (n == 0 || n == 63)
                check($sformatf("sf_m_valid_before_n%0d", n),
                      32'(bus.m_valid), 0);
            push1(0, n, n == 63);
        end
        check("sf_latency_m_valid", 32'(bus.m_valid), 1);
        drain(0, 1, 1'b0, 50, 1'b1);

        // Backpressure: both banks fill, writer blocks.
        produce(10, 2, 1'b0, 300);
        check("bp_s_ready_low", 32'(bus.s_ready), 0);
        check("bp_m_valid", 32'(bus.m_valid), 1);
        bus.s_valid = 1'b1;
        bus.s_data  = smp(12, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_blocked", 32'(bus.s_ready), 0);
        end
        bus.s_valid = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus.m_ready = 1'b1;
            check($sformatf("bp_no_bypass_r%0d", r), 32'(bus.s_ready), 0);
            check_row(10, r);
            @(negedge clk);
        end
        bus.m_ready = 1'b0;
        check("bp_s_ready_rise", 32'(bus.s_ready), 1);

        // Refill while the second frame drains under a stalling consumer.
        fork
            produce(12, 1, 1'b0, 400);
            drain(11, 2, 1'b1, 800, 1'b1);
        join

        // Continuous stream, four frames.
        fork
            produce(20, 4, 1'b1, 600);
            drain(20, 4, 1'b0, 600, 1'b1);
        join

`ifdef FFT64_STAGER_FRAME_CHK_EN
        check("fc_err_clear", 32'(bus.frame_err), 0);
        for (int n = 0; n < 64; n++) begin
            push1(30, n, n == 40);
            if (n == 39)
                check("fc_err_before", 32'(bus.frame_err), 0);
            if (n == 40)
                check("fc_err_set", 32'(bus.frame_err), 1);
        end
        drain(30, 1, 1'b0, 50, 1'b1);
        check("fc_err_sticky", 32'(bus.frame_err), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
